// File: rtl/eth_link_supervisor.sv
// eth_link_supervisor
// Multi-lane link supervisor for the 10G Ethernet subsystem (tx_clk domain).
// Each lane qualifies PCS block lock into a debounced link_up, requests a GT
// reset when lock stays absent for too long, and keeps saturating counters
// for MAC/FIFO status events and for link drops. All counters are read
// through one registered read port, optionally cleared by the read itself.
module eth_link_supervisor #(
    parameter int CHANNELS       = 4,
    parameter int NUM_EVT        = 9,
    parameter int CNT_W          = 32,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int RST_PULSE      = 16,
    parameter int CLEAR_ON_READ  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNELS-1:0]               rx_block_lock,
    input  logic [CHANNELS*NUM_EVT-1:0]       evt_in,
    input  logic                              auto_reset_en,
    output logic [CHANNELS-1:0]               link_up,
    output logic [CHANNELS-1:0]               gt_reset_req,
    input  logic                              rd_en,
    input  logic [$clog2(CHANNELS):0]         rd_ch,
    input  logic [$clog2(NUM_EVT+1):0]        rd_sel,
    output logic [CNT_W-1:0]                  rd_data,
    output logic                              rd_valid
);

    localparam int CH_W   = $clog2(CHANNELS) + 1;
    localparam int SEL_W  = $clog2(NUM_EVT + 1) + 1;
    localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RP_W   = $clog2(RST_PULSE) + 1;

    localparam logic [1:0] ST_DOWN    = 2'd0;
    localparam logic [1:0] ST_UP      = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RP_W-1:0]   RP_LAST   = RP_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic              CLR_ON_RD = (CLEAR_ON_READ != 0);

    // One-cycle pulse per lane when an UP lane loses lock (feeds drop counter)
    logic [CHANNELS-1:0] w_drop;

    // ------------------------------------------------------------------
    // Per-lane link FSM
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [1:0]        r_state;
        logic [1:0]        w_state_nxt;
        logic [LOCK_W-1:0] r_lock_cnt;
        logic [LOCK_W-1:0] w_lock_nxt;
        logic [TO_W-1:0]   r_to_cnt;
        logic [TO_W-1:0]   w_to_nxt;
        logic [RP_W-1:0]   r_rp_cnt;
        logic [RP_W-1:0]   w_rp_nxt;
        logic              r_link;
        logic              r_req;
        logic              w_drop_l;

        // Next-state and timer update for this lane
        always_comb begin
            w_state_nxt = r_state;
            w_lock_nxt  = r_lock_cnt;
            w_to_nxt    = r_to_cnt;
            w_rp_nxt    = r_rp_cnt;
            w_drop_l    = 1'b0;
            case (r_state)
                ST_DOWN: begin
                    w_rp_nxt = {RP_W{1'b0}};
                    if (rx_block_lock[c]) begin
                        w_lock_nxt = r_lock_cnt + 1'b1;
                    end else begin
                        w_lock_nxt = {LOCK_W{1'b0}};
                    end
                    // Timeout counter parks at its last value while recovery is disabled
                    if (r_to_cnt != TO_LAST) begin
                        w_to_nxt = r_to_cnt + 1'b1;
                    end else begin
                        w_to_nxt = r_to_cnt;
                    end
                    // A qualified lock wins over a simultaneous timeout
                    if (rx_block_lock[c] && (r_lock_cnt == LOCK_LAST)) begin
                        w_state_nxt = ST_UP;
                        w_lock_nxt  = {LOCK_W{1'b0}};
                        w_to_nxt    = {TO_W{1'b0}};
                    end else if ((r_to_cnt == TO_LAST) && auto_reset_en) begin
                        w_state_nxt = ST_RECOVER;
                        w_lock_nxt  = {LOCK_W{1'b0}};
                        w_to_nxt    = {TO_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_DOWN;
                    end
                end
                ST_UP: begin
                    w_lock_nxt = {LOCK_W{1'b0}};
                    w_to_nxt   = {TO_W{1'b0}};
                    w_rp_nxt   = {RP_W{1'b0}};
                    if (!rx_block_lock[c]) begin
                        w_state_nxt = ST_DOWN;
                        w_drop_l    = 1'b1;
                    end else begin
                        w_state_nxt = ST_UP;
                    end
                end
                ST_RECOVER: begin
                    // Lock is deliberately ignored while the GT is being reset
                    w_lock_nxt = {LOCK_W{1'b0}};
                    w_to_nxt   = {TO_W{1'b0}};
                    if (r_rp_cnt == RP_LAST) begin
                        w_state_nxt = ST_DOWN;
                        w_rp_nxt    = {RP_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_RECOVER;
                        w_rp_nxt    = r_rp_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_DOWN;
                    w_lock_nxt  = {LOCK_W{1'b0}};
                    w_to_nxt    = {TO_W{1'b0}};
                    w_rp_nxt    = {RP_W{1'b0}};
                end
            endcase
        end

        // State, timers and outputs decoded from the next state so they move together
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state    <= ST_DOWN;
                r_lock_cnt <= {LOCK_W{1'b0}};
                r_to_cnt   <= {TO_W{1'b0}};
                r_rp_cnt   <= {RP_W{1'b0}};
                r_link     <= 1'b0;
                r_req      <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_lock_cnt <= w_lock_nxt;
                r_to_cnt   <= w_to_nxt;
                r_rp_cnt   <= w_rp_nxt;
                r_link     <= (w_state_nxt == ST_UP);
                r_req      <= (w_state_nxt == ST_RECOVER);
            end
        end

        assign link_up[c]      = r_link;
        assign gt_reset_req[c] = r_req;
        assign w_drop[c]       = w_drop_l;
    end

    // ------------------------------------------------------------------
    // Counter bank: NUM_EVT event counters plus one drop counter per lane
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt [CHANNELS][NUM_EVT+1];
    logic [NUM_EVT:0] w_inc [CHANNELS];
    logic [NUM_EVT:0] w_hit [CHANNELS];
    logic [CNT_W-1:0] w_rd_val;

    // Increment sources, read-address decode and read mux (out-of-range hits nothing -> 0)
    always_comb begin
        w_rd_val = {CNT_W{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            for (int e = 0; e < NUM_EVT; e++) begin
                w_inc[c][e] = evt_in[c*NUM_EVT + e];
            end
            w_inc[c][NUM_EVT] = w_drop[c];
            for (int e = 0; e <= NUM_EVT; e++) begin
                w_hit[c][e] = rd_en && (rd_ch == CH_W'(c)) && (rd_sel == SEL_W'(e));
                if (w_hit[c][e]) begin
                    w_rd_val = r_cnt[c][e];
                end else begin
                    w_rd_val = w_rd_val;
                end
            end
        end
    end

    // Saturating counters; a clearing read keeps a coincident event as the new count
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int e = 0; e <= NUM_EVT; e++) begin
                    r_cnt[c][e] <= {CNT_W{1'b0}};
                end
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int e = 0; e <= NUM_EVT; e++) begin
                    if (CLR_ON_RD && w_hit[c][e]) begin
                        r_cnt[c][e] <= CNT_W'(w_inc[c][e]);
                    end else if (w_inc[c][e] && (r_cnt[c][e] != CNT_MAX)) begin
                        r_cnt[c][e] <= r_cnt[c][e] + 1'b1;
                    end else begin
                        r_cnt[c][e] <= r_cnt[c][e];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_valid;

    // Capture the selected counter one cycle after the strobe; data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= {CNT_W{1'b0}};
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_val;
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_eth_link_supervisor.sv
// Self-checking bench for eth_link_supervisor: a table of per-cycle vectors
// for counters/reads, plus hand-written sequences for lock qualification,
// link drop, auto-recovery timing and reset during recovery/read.
module tb_eth_link_supervisor;

    localparam int CHANNELS = 2;
    localparam int NUM_EVT  = 9;
    localparam int CNT_W    = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  rx_block_lock;
    logic [17:0] evt_in;
    logic        auto_reset_en;
    logic [1:0]  link_up;
    logic [1:0]  gt_reset_req;
    logic        rd_en;
    logic [1:0]  rd_ch;
    logic [4:0]  rd_sel;
    logic [3:0]  rd_data;
    logic        rd_valid;

    int n_tests = 0;
    int n_fail  = 0;

    eth_link_supervisor #(
        .CHANNELS       (CHANNELS),
        .NUM_EVT        (NUM_EVT),
        .CNT_W          (CNT_W),
        .LOCK_CYCLES    (8),
        .TIMEOUT_CYCLES (32),
        .RST_PULSE      (4),
        .CLEAR_ON_READ  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_block_lock (rx_block_lock),
        .evt_in        (evt_in),
        .auto_reset_en (auto_reset_en),
        .link_up       (link_up),
        .gt_reset_req  (gt_reset_req),
        .rd_en         (rd_en),
        .rd_ch         (rd_ch),
        .rd_sel        (rd_sel),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  lock;
        logic [17:0] evt;
        logic        rd_en;
        logic [1:0]  rd_ch;
        logic [4:0]  rd_sel;
        logic [1:0]  exp_link;
        logic        exp_valid;
        logic [3:0]  exp_data;
    } vec_t;

    vec_t tbl[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic r, input logic [1:0] lk, input logic [17:0] ev,
                           input logic re, input logic [1:0] ch, input logic [4:0] sel,
                           input logic [1:0] xl, input logic xv, input logic [3:0] xd);
        vec_t v;
        v.rst = r; v.lock = lk; v.evt = ev; v.rd_en = re; v.rd_ch = ch; v.rd_sel = sel;
        v.exp_link = xl; v.exp_valid = xv; v.exp_data = xd;
        tbl.push_back(v);
    endtask

    task automatic rd_issue(input logic [1:0] ch, input logic [4:0] sel);
        rd_en = 1'b1; rd_ch = ch; rd_sel = sel;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        logic [17:0] ev;
        logic [1:0]  exp2;

        rst = 1'b1; rx_block_lock = 2'b00; evt_in = 18'h0; auto_reset_en = 1'b0;
        rd_en = 1'b0; rd_ch = 2'd0; rd_sel = 5'd0;
        tick(); tick();
        chk("init_link", 32'(link_up), 32'h0);
        chk("init_req", 32'(gt_reset_req), 32'h0);
        chk("init_valid", 32'(rd_valid), 32'h0);
        chk("init_data", 32'(rd_data), 32'h0);

        // ---------------- table: counters, reads, lane-1 lock/drop ----------------
        add_vec(1'b1, 2'b00, 18'h0, 1'b0, 2'd0, 5'd0, 2'b00, 1'b0, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            ev = 18'h00008;
            if (i <= 5) ev = ev | 18'h00200;
            if (i <= 2) ev = ev | 18'h20000;
            add_vec(1'b0, 2'b10, ev, 1'b0, 2'd0, 5'd0, (i >= 8) ? 2'b10 : 2'b00, 1'b0, 4'd0);
        end
        add_vec(1'b0, 2'b10, 18'h00008, 1'b1, 2'd0, 5'd3,  2'b10, 1'b1, 4'd15); // saturated, coincident pulse
        add_vec(1'b0, 2'b10, 18'h0,     1'b0, 2'd0, 5'd0,  2'b10, 1'b0, 4'd15); // data holds
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd0, 5'd3,  2'b10, 1'b1, 4'd1);  // pulse kept
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd0, 5'd3,  2'b10, 1'b1, 4'd0);  // cleared
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd1, 5'd8,  2'b10, 1'b1, 4'd2);
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd2, 5'd0,  2'b10, 1'b1, 4'd0);  // channel out of range
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd1, 5'd0,  2'b10, 1'b1, 4'd5);
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd1, 5'd10, 2'b10, 1'b1, 4'd0);  // select out of range
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd3, 5'd9,  2'b10, 1'b1, 4'd0);
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd1, 5'd8,  2'b10, 1'b1, 4'd0);
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd1, 5'd0,  2'b10, 1'b1, 4'd0);
        add_vec(1'b0, 2'b10, 18'h0,     1'b1, 2'd1, 5'd9,  2'b10, 1'b1, 4'd0);
        add_vec(1'b0, 2'b00, 18'h0,     1'b0, 2'd0, 5'd0,  2'b00, 1'b0, 4'd0);  // lane 1 drops
        add_vec(1'b0, 2'b00, 18'h0,     1'b1, 2'd1, 5'd9,  2'b00, 1'b1, 4'd1);  // drop count

        foreach (tbl[i]) begin
            rst = tbl[i].rst; rx_block_lock = tbl[i].lock; evt_in = tbl[i].evt;
            rd_en = tbl[i].rd_en; rd_ch = tbl[i].rd_ch; rd_sel = tbl[i].rd_sel;
            tick();
            chk($sformatf("vec%0d_link", i),  32'(link_up),      32'(tbl[i].exp_link));
            chk($sformatf("vec%0d_req", i),   32'(gt_reset_req), 32'h0);
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid),     32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_data", i),  32'(rd_data),      32'(tbl[i].exp_data));
        end
        rst = 1'b0; evt_in = 18'h0; rd_en = 1'b0;

        // ---------------- synchronous reset clears the read port ----------------
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_data", 32'(rd_data), 32'h0);
        chk("rst_valid", 32'(rd_valid), 32'h0);
        chk("rst_link", 32'(link_up), 32'h0);

        // ---------------- lock qualification and drop on lane 0 ----------------
        rx_block_lock = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("acq1_k%0d", k), 32'(link_up), (k == 8) ? 32'h1 : 32'h0);
        end
        rx_block_lock = 2'b00;
        tick();
        chk("drop_link", 32'(link_up), 32'h0);
        rx_block_lock = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("acq2_k%0d", k), 32'(link_up), (k == 8) ? 32'h1 : 32'h0);
        end
        rd_issue(2'd0, 5'd9);
        chk("drop0_valid", 32'(rd_valid), 32'h1);
        chk("drop0_data", 32'(rd_data), 32'h1);
        rd_issue(2'd1, 5'd9);
        chk("drop1_data", 32'(rd_data), 32'h0);
        rd_issue(2'd0, 5'd9);
        chk("drop0_clr", 32'(rd_data), 32'h0);
        chk("acq_req", 32'(gt_reset_req), 32'h0);
        tick();
        chk("rdv_pulse", 32'(rd_valid), 32'h0);

        // ---------------- auto-recovery timing ----------------
        rx_block_lock = 2'b00; auto_reset_en = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 1; n <= 75; n++) begin
            tick();
            exp2 = (((n >= 32) && (n <= 35)) || ((n >= 68) && (n <= 71))) ? 2'b11 : 2'b00;
            chk($sformatf("rec_n%0d", n), 32'(gt_reset_req), 32'(exp2));
            if (link_up !== 2'b00) chk($sformatf("rec_link_n%0d", n), 32'(link_up), 32'h0);
        end

        // ---------------- recovery disabled: never a request ----------------
        auto_reset_en = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            chk($sformatf("norec_n%0d", n), 32'(gt_reset_req), 32'h0);
        end

        // ---------------- reset during RECOVER and during a read ----------------
        auto_reset_en = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        evt_in = 18'h3FFFF;
        tick(); tick(); tick();
        evt_in = 18'h0;
        rd_issue(2'd1, 5'd5);
        chk("pre_rst_valid", 32'(rd_valid), 32'h1);
        chk("pre_rst_data", 32'(rd_data), 32'h3);
        for (int n = 5; n <= 32; n++) tick();
        chk("pre_rst_req32", 32'(gt_reset_req), 32'h3);
        tick();
        chk("pre_rst_req33", 32'(gt_reset_req), 32'h3);
        rst = 1'b1; rd_en = 1'b1; rd_ch = 2'd0; rd_sel = 5'd0;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        chk("mid_rst_req", 32'(gt_reset_req), 32'h0);
        chk("mid_rst_valid", 32'(rd_valid), 32'h0);
        chk("mid_rst_link", 32'(link_up), 32'h0);
        chk("mid_rst_data", 32'(rd_data), 32'h0);
        for (int c = 0; c < CHANNELS; c++) begin
            for (int s = 0; s <= NUM_EVT; s++) begin
                rd_issue(2'(c), 5'(s));
                chk($sformatf("post_rst_c%0d_s%0d_valid", c, s), 32'(rd_valid), 32'h1);
                chk($sformatf("post_rst_c%0d_s%0d_data", c, s), 32'(rd_data), 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
